// File: rtl/fir_sym_pipe_param_if.sv
// fir_sym_pipe_param_if: sample/coefficient bus of the symmetric FIR filter.
//   master : drives the sample stream (in_valid, x_in, sym_en), flush and the
//            coefficient write port (coef_we, coef_addr, coef_data); reads
//            out_valid / y_out.
//   slave  : the filter side.
interface fir_sym_pipe_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 32,
  parameter int OUT_W  = 32
);
  localparam int AW = $clog2(TAPS);

  logic                     in_valid;
  logic signed [DATA_W-1:0] x_in;
  logic                     sym_en;
  logic                     flush;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  y_out;

  modport master (
    output in_valid, x_in, sym_en, flush, coef_we, coef_addr, coef_data,
    input  out_valid, y_out
  );

  modport slave (
    input  in_valid, x_in, sym_en, flush, coef_we, coef_addr, coef_data,
    output out_valid, y_out
  );
endinterface

// File: rtl/fir_sym_pipe_param.sv
// fir_sym_pipe_param: parametrised, fully pipelined direct-form FIR filter with
// run-time selectable symmetric (pre-add folded) or general mode.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset.
//   bus (slave): in_valid/x_in/sym_en sample stream, flush, coefficient write
//                port coef_we/coef_addr/coef_data, out_valid/y_out result.
// Pipeline: accept edge t (delay line shifts), products at t+1, sum/output at
// t+2, so out_valid is high in the cycle after edge t+2.
// Optional feature: define FIR_SAT_EN to saturate the shifted sum to OUT_W
// bits; otherwise the sum is truncated (two's-complement wrap).

// One tap: optional pre-add, then registered product.
// KIND 0 = lower half (folded with its mirror tap in symmetric mode),
// KIND 1 = middle tap of an odd-length filter, KIND 2 = upper half
// (contributes nothing in symmetric mode).
module fir_sym_tap #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int KIND   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [DATA_W-1:0]        x_a,
  input  logic signed [DATA_W-1:0]        x_b,
  input  logic signed [COEF_W-1:0]        c,
  input  logic                            sym,
  output logic signed [DATA_W+COEF_W:0]   p
);
  localparam int PW = DATA_W + COEF_W + 1;

  logic signed [DATA_W:0] pre;
  logic [PW-1:0]          pre_x, c_x, prod;

  always_comb begin
    pre = {x_a[DATA_W-1], x_a};
    if (sym) begin
      if (KIND == 0)      pre = {x_a[DATA_W-1], x_a} + {x_b[DATA_W-1], x_b};
      else if (KIND == 2) pre = '0;
    end
  end

  // Both operands sign-extended to the product width so the low PW bits of
  // the unsigned multiply equal the signed product.
  assign pre_x = {{COEF_W{pre[DATA_W]}}, pre};
  assign c_x   = {{(DATA_W+1){c[COEF_W-1]}}, c};
  assign prod  = pre_x * c_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= prod;
  end
endmodule

module fir_sym_pipe_param #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 32,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fir_sym_pipe_param_if.slave    bus
);
  localparam int PW     = DATA_W + COEF_W + 1;
  localparam int LG     = $clog2(TAPS);
  localparam int SW     = PW + LG;
  localparam int STAGES = 2;

  logic [TAPS-1:0][DATA_W-1:0] xd;
  logic [TAPS-1:0][COEF_W-1:0] coef;
  logic [TAPS-1:0][PW-1:0]     prod;
  logic [STAGES:0]             vld_pipe;
  logic                        sym_q;
  logic signed [SW-1:0]        sum, sh;
  logic signed [OUT_W-1:0]     y_nxt, y_q;

  // Delay line, mode tag and valid shift register. vld_pipe[0] marks an
  // accept, [1] valid products, [2] is out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xd       <= '0;
      vld_pipe <= '0;
      sym_q    <= 1'b0;
    end else if (bus.flush) begin
      xd       <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
      if (bus.in_valid) begin
        xd    <= {xd[TAPS-2:0], bus.x_in};
        sym_q <= bus.sym_en;
      end
    end
  end

  // Out-of-range addresses are dropped; flush does not block writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      coef <= '0;
    else if (bus.coef_we && (int'(bus.coef_addr) < TAPS))
      coef[bus.coef_addr] <= bus.coef_data;
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    localparam int KIND = (i < TAPS/2) ? 0 :
                          (((TAPS % 2) == 1) && (i == TAPS/2)) ? 1 : 2;
    fir_sym_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W), .KIND(KIND)) u_tap (
      .clk   (clk),
      .rst_n (rst_n),
      .x_a   (xd[i]),
      .x_b   (xd[TAPS-1-i]),
      .c     (coef[i]),
      .sym   (sym_q),
      .p     (prod[i])
    );
  end

  // Full-precision adder: LG guard bits cover TAPS products.
  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++)
      sum = sum + {{LG{prod[i][PW-1]}}, prod[i]};
  end

  assign sh = sum >>> OUT_SHIFT;

  if (SW > OUT_W) begin : g_narrow
`ifdef FIR_SAT_EN
    always_comb begin
      if ((&sh[SW-1:OUT_W-1]) || !(|sh[SW-1:OUT_W-1]))
        y_nxt = sh[OUT_W-1:0];
      else if (sh[SW-1])
        y_nxt = {1'b1, {(OUT_W-1){1'b0}}};
      else
        y_nxt = {1'b0, {(OUT_W-1){1'b1}}};
    end
`else
    logic unused_hi;
    assign y_nxt     = sh[OUT_W-1:0];
    assign unused_hi = ^sh[SW-1:OUT_W];
`endif
  end else begin : g_wide
    assign y_nxt = OUT_W'(sh);
  end

  // y_out only moves on a valid result; a flush on the same edge keeps it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        y_q <= '0;
    else if (!bus.flush && vld_pipe[1]) y_q <= y_nxt;
  end

  assign bus.y_out     = y_q;
  assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fir_sym_pipe_param.sv
module tb_fir_sym_pipe_param;
  localparam int DW = 16, CW = 16, NT = 32, OW = 32, NT2 = 5;
  localparam int AW = $clog2(NT), AW2 = $clog2(NT2);
`ifdef FIR_SAT_EN
  localparam longint OVF_EXP = 64'sd2147483647;
`else
  localparam longint OVF_EXP = -64'sd2097120;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fir_sym_pipe_param_if #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT),  .OUT_W(OW)) b();
  fir_sym_pipe_param_if #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT2), .OUT_W(OW)) b2();

  fir_sym_pipe_param #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT), .OUT_W(OW), .OUT_SHIFT(0))
    dut (.clk(clk), .rst_n(rst_n), .bus(b));
  fir_sym_pipe_param #(.DATA_W(DW), .COEF_W(CW), .TAPS(NT2), .OUT_W(OW), .OUT_SHIFT(0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int nvec = 0, nfail = 0, cyc = 0, mon_a;
  int acc[$];
  longint outs[$], outs2[$];

  typedef struct {
    string  nm;
    int     ck;    // 0: c=i+1, 1: c[0..15]=1 c[16..31]=99, 2: all 32767, 3: all 0
    logic   sym;
    int     x0;    // first sample
    int     xr;    // remaining samples
    int     n;     // number of samples
    int     idx;   // output strobe index to check
    longint expv;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic missing(input string nm);
    nvec++;
    nfail++;
    $display("FAIL %s: output strobe missing", nm);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match an accepted sample exactly two edges later.
  always @(negedge clk) begin
    if (rst_n && b.out_valid) begin
      if (acc.size() == 0) chk("stale_strobe", 1, 0);
      else begin
        mon_a = acc.pop_front();
        chk("latency", longint'(cyc), longint'(mon_a + 2));
      end
      outs.push_back(longint'(b.y_out));
    end
  end

  always @(negedge clk)
    if (rst_n && b2.out_valid) outs2.push_back(longint'(b2.y_out));

  // Called at a negedge; the following posedge applies the inputs.
  task automatic cyc1(input logic v, input int x, input logic s, input logic fl,
                      input logic we, input int a, input int d);
    b.in_valid  = v;
    b.x_in      = DW'(x);
    b.sym_en    = s;
    b.flush     = fl;
    b.coef_we   = we;
    b.coef_addr = AW'(a);
    b.coef_data = CW'(d);
    if (v && !fl) acc.push_back(cyc + 1);
    @(negedge clk);
    if (fl) acc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic load_coef(input int kind);
    int val;
    for (int i = 0; i < NT; i++) begin
      case (kind)
        0:       val = i + 1;
        1:       val = (i < 16) ? 1 : 99;
        2:       val = 32767;
        default: val = 0;
      endcase
      cyc1(1'b0, 0, 1'b0, 1'b0, 1'b1, i, val);
    end
  endtask

  task automatic cyc2(input logic v, input int x, input logic s,
                      input logic we, input int a, input int d);
    b2.in_valid  = v;
    b2.x_in      = DW'(x);
    b2.sym_en    = s;
    b2.flush     = 1'b0;
    b2.coef_we   = we;
    b2.coef_addr = AW2'(a);
    b2.coef_data = CW'(d);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   e2 [11] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 2, 1};

    vt.push_back('{"imp_g0",   0, 1'b0,  1,   0,   32,  0,  1});
    vt.push_back('{"imp_g1",   0, 1'b0,  1,   0,   32,  1,  2});
    vt.push_back('{"imp_g15",  0, 1'b0,  1,   0,   32, 15, 16});
    vt.push_back('{"imp_g31",  0, 1'b0,  1,   0,   32, 31, 32});
    vt.push_back('{"imp_neg4", 0, 1'b0, -3,   0,   32,  4, -15});
    vt.push_back('{"sym_s0",   1, 1'b1, 100, 100,  40,  0, 100});
    vt.push_back('{"sym_s15",  1, 1'b1, 100, 100,  40, 15, 1600});
    vt.push_back('{"sym_s16",  1, 1'b1, 100, 100,  40, 16, 1700});
    vt.push_back('{"sym_s31",  1, 1'b1, 100, 100,  40, 31, 3200});
    vt.push_back('{"sym_s39",  1, 1'b1, 100, 100,  40, 39, 3200});
    vt.push_back('{"gen_s3",   1, 1'b0, 100, 100,  40,  3, 400});
    vt.push_back('{"gen_s19",  1, 1'b0, 100, 100,  40, 19, 41200});
    vt.push_back('{"ovf0",     2, 1'b0, 32767, 32767, 40,  0, 1073676289});
    vt.push_back('{"ovf39",    2, 1'b0, 32767, 32767, 40, 39, OVF_EXP});

    b.in_valid = 0; b.x_in = '0; b.sym_en = 0; b.flush = 0;
    b.coef_we = 0; b.coef_addr = '0; b.coef_data = '0;
    b2.in_valid = 0; b2.x_in = '0; b2.sym_en = 0; b2.flush = 0;
    b2.coef_we = 0; b2.coef_addr = '0; b2.coef_data = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", longint'(b.out_valid), 0);
    chk("rst_y_out", longint'(b.y_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Odd-length filter: out-of-range addresses, general impulse, folded impulse
    for (int i = 0; i < 8; i++) cyc2(1'b0, 0, 1'b0, 1'b1, i, (i < NT2) ? i + 1 : 77);
    cyc2(1'b1, 1, 1'b0, 1'b0, 0, 0);
    repeat (5) cyc2(1'b1, 0, 1'b0, 1'b0, 0, 0);
    cyc2(1'b1, 1, 1'b1, 1'b0, 0, 0);
    repeat (4) cyc2(1'b1, 0, 1'b1, 1'b0, 0, 0);
    repeat (4) cyc2(1'b0, 0, 1'b0, 1'b0, 0, 0);
    chk("t5_cnt", longint'(outs2.size()), 11);
    for (int i = 0; i < 11; i++)
      if (i < outs2.size()) chk($sformatf("t5_out%0d", i), outs2[i], e2[i]);
      else missing($sformatf("t5_out%0d", i));

    // Table-driven vectors
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      cyc1(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
      load_coef(v.ck);
      outs.delete();
      for (int k = 0; k < v.n; k++)
        cyc1(1'b1, (k == 0) ? v.x0 : v.xr, v.sym, 1'b0, 1'b0, 0, 0);
      idle(4);
      chk({v.nm, "_cnt"}, longint'(outs.size()), longint'(v.n));
      if (v.idx < outs.size()) chk(v.nm, outs[v.idx], v.expv);
      else missing(v.nm);
    end

    // Gapped input: accept every third cycle
    cyc1(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    load_coef(0);
    outs.delete();
    for (int k = 0; k < 6; k++) begin
      cyc1(1'b1, (k == 0) ? 1 : 0, 1'b0, 1'b0, 1'b0, 0, 0);
      idle(2);
    end
    idle(3);
    chk("gap_cnt", longint'(outs.size()), 6);
    if (outs.size() == 6) chk("gap_last", outs[5], 6);
    else missing("gap_last");
    chk("gap_pending", longint'(acc.size()), 0);

    // Flush with a simultaneous sample, two samples in flight
    cyc1(1'b1, 5, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc1(1'b1, 5, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc1(1'b1, 7, 1'b0, 1'b1, 1'b0, 0, 0);
    chk("flush_ov", longint'(b.out_valid), 0);
    chk("flush_hold", longint'(b.y_out), 6);
    idle(3);
    outs.delete();
    cyc1(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(4);
    chk("flush_cnt", longint'(outs.size()), 1);
    if (outs.size() > 0) chk("flush_after", outs[0], 1);
    else missing("flush_after");

    // Mode change between samples
    cyc1(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0);
    load_coef(0);
    outs.delete();
    cyc1(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (30) cyc1(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc1(1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc1(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(4);
    chk("flip_cnt", longint'(outs.size()), 33);
    if (outs.size() == 33) begin
      chk("flip_gen30", outs[30], 31);
      chk("flip_sym31", outs[31], 1);
      chk("flip_gen32", outs[32], 0);
    end else missing("flip_seq");

    // Coefficient write on the accept edge; write during flush
    load_coef(3);
    cyc1(1'b0, 0, 1'b0, 1'b1, 1'b1, 1, 3);
    outs.delete();
    cyc1(1'b1, 2, 1'b0, 1'b0, 1'b1, 0, 5);
    cyc1(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(4);
    chk("cw_cnt", longint'(outs.size()), 2);
    if (outs.size() == 2) begin
      chk("cw_same_edge", outs[0], 10);
      chk("cw_during_flush", outs[1], 6);
    end else missing("cw_seq");

    // Async reset with two samples in flight
    load_coef(0);
    cyc1(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc1(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ov", longint'(b.out_valid), 0);
    chk("rst_mid_y", longint'(b.y_out), 0);
    acc.delete();
    b.in_valid = 0; b.coef_we = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    outs.delete();
    idle(4);
    chk("rst_no_strobe", longint'(outs.size()), 0);
    cyc1(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    idle(4);
    chk("rst_imp_cnt", longint'(outs.size()), 1);
    if (outs.size() > 0) chk("rst_coef_zero", outs[0], 0);
    else missing("rst_coef_zero");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
